e_mdu_ctrl: RTL and testbench
=============================

Name: e_mdu_ctrl

Overview:
- Multiply/divide controller for the execute stage.
- Takes issued MD operations and the forwarded RS/RT operands, and sequences a fixed-latency multiply or divide.
- Owns the HI/LO registers and raises busy and stall so the D stage holds dependent MD instructions.
- Sits beside the E-stage ALU; HI/LO are read by the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (low = reset).
- E_md_start  input  1  E-stage instruction is an MD op this cycle; qualifies E_md_op.
- E_md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others NONE.
- E_RS_DATA  input  32  forwarded rs operand.
- E_RT_DATA  input  32  forwarded rt operand.
- D_md_req  input  1  D-stage instruction is any MD op, including MFHI/MFLO/MTHI/MTLO.
- md_busy  output  1  long operation in flight.
- md_stall  output  1  stall request to hazard unit.
- HI  output  32  HI register.
- LO  output  32  LO register.
- md_err  output  1  sticky: a start was issued while busy.

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, md_busy=0, cycle counter=0, md_err=0, latched result cleared. Any in-flight operation is discarded. Release is synchronous to the next clk edge.
- States:
  - IDLE (md_busy=0).
  - RUN (md_busy=1, counter in 1..N).
- IDLE, start with op in MULT/MULTU/DIV/DIVU at edge t:
  - Full 64-bit result is computed from that cycle's operands and latched internally.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); move to RUN.
  - md_busy is high for exactly N cycles after edge t.
- RUN: counter decrements each edge. At the edge where counter==1, HI/LO take the latched result, counter→0, move to IDLE. New HI/LO are visible in the first cycle md_busy is low. HI/LO hold their old values throughout RUN.
- MTHI/MTLO, IDLE: HI (or LO) = E_RS_DATA at the next edge. No busy.
- Arithmetic:
  - MULT: signed 32x32→64. MULTU: unsigned 32x32→64. HI = result[63:32], LO = result[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: busy runs the full DIV_CYCLES, HI/LO unchanged at completion.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Start while busy (any op, including MTHI/MTLO): ignored, state unaffected, md_err set to 1 until reset. The hazard unit must prevent this.
- md_stall (combinational) = D_md_req & (md_busy | (E_md_start & E_md_op in MULT..DIVU or MADD/MADDU when enabled)).
- E_md_start with op NONE or an unlisted op: no effect.
- Completion edge with a simultaneous start is impossible: md_busy is still 1 during the completion cycle, so the start counts as start-while-busy.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} += signed(rs)*signed(rt).
  - MADDU: same, unsigned product.
  - Both use MULT_CYCLES. The accumulate uses the HI/LO value at the start edge; the 64-bit sum wraps modulo 2^64.
- Undefined: ops 7/8 decode as NONE. No stall contribution, HI/LO untouched, md_err unaffected.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 → md_busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → busy 10 cycles, HI/LO unchanged.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → HI/LO updated one edge after each; md_busy never asserted.
- During DIV busy: hold D_md_req=1 → md_stall=1 every busy cycle and 0 on the first idle cycle. Pulse start with MULT mid-run → ignored, md_err=1, DIV result unchanged.
- Assert reset low at busy cycle 3 of MULT → md_busy, HI, LO read 0 immediately (asynchronously). After release, an MFHI-type D_md_req gives md_stall=0.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU rs=1, rt=1 → HI=1, LO=0 after 5 cycles. Without the macro: same stimulus leaves HI/LO unchanged, busy stays 0.

Source files
------------

// File: rtl/e_mdu_ctrl_if.sv
// Execute-stage MD port bundle: the issue side drives op/operands/D-stage request;
// the controller returns busy/stall/HI/LO/error.
interface e_mdu_ctrl_if;
  logic        E_md_start;
  logic [3:0]  E_md_op;
  logic [31:0] E_RS_DATA;
  logic [31:0] E_RT_DATA;
  logic        D_md_req;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        md_err;

  // Issue is level-qualified: E_md_op/E_RS_DATA/E_RT_DATA are meaningful only in
  // cycles where E_md_start is 1; a start is accepted only while md_busy is 0.
  modport master (
    output E_md_start, E_md_op, E_RS_DATA, E_RT_DATA, D_md_req,
    input  md_busy, md_stall, HI, LO, md_err
  );
  modport slave (
    input  E_md_start, E_md_op, E_RS_DATA, E_RT_DATA, D_md_req,
    output md_busy, md_stall, HI, LO, md_err
  );
endinterface

// File: rtl/e_mdu_ctrl.sv
// Fixed-latency multiply/divide controller owning HI/LO for the execute stage.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  e_mdu_ctrl_if.slave md,
  output logic [0:0] dbg_state
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [63:0] res_q;
  logic        res_wr_q;
  logic [31:0] hi_q, lo_q;
  logic        err_q;

  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        is_mul, is_div, is_madd, is_mt, long_op, known_op;
  logic        mul_signed, div_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quo, rem;
  logic [63:0] res_next;
  logic        res_wr_next;

  assign op = md.E_md_op;
  assign rs = md.E_RS_DATA;
  assign rt = md.E_RT_DATA;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
`ifdef MDU_MADD_EN
  assign is_madd = (op == OP_MADD) || (op == OP_MADDU);
`else
  assign is_madd = 1'b0;
`endif
  assign long_op  = is_mul || is_div || is_madd;
  assign known_op = long_op || is_mt;

  // One 64x64 multiplier serves signed and unsigned forms via operand extension.
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD);
  assign mul_a = {{32{mul_signed & rs[31]}}, rs};
  assign mul_b = {{32{mul_signed & rt[31]}}, rt};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    div_signed = (op == OP_DIV);
    dvd_neg  = div_signed & rs[31];
    dvs_neg  = div_signed & rt[31];
    dvd_mag  = dvd_neg ? (~rs + 32'd1) : rs;
    dvs_mag  = dvs_neg ? (~rt + 32'd1) : rt;
    dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
    q_mag    = dvd_mag / dvs_safe;
    r_mag    = dvd_mag % dvs_safe;
    quo      = (dvd_neg ^ dvs_neg) ? (~q_mag + 32'd1) : q_mag;
    rem      = dvd_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    res_next    = prod;
    res_wr_next = 1'b1;
    if (is_div) begin
      res_next    = {rem, quo};
      res_wr_next = (rt != 32'd0);
    end else if (is_madd) begin
      res_next = {hi_q, lo_q} + prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      res_q    <= 64'd0;
      res_wr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      err_q    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (md.E_md_start && long_op) begin
        res_q    <= res_next;
        res_wr_q <= res_wr_next;
        cnt      <= is_div ? DIV_N : MULT_N;
        state    <= S_RUN;
      end else if (md.E_md_start && (op == OP_MTHI)) begin
        hi_q <= rs;
      end else if (md.E_md_start && (op == OP_MTLO)) begin
        lo_q <= rs;
      end
    end else begin
      if (md.E_md_start && known_op) err_q <= 1'b1;
      if (cnt == 4'd1) begin
        if (res_wr_q) begin
          hi_q <= res_q[63:32];
          lo_q <= res_q[31:0];
        end
        cnt   <= 4'd0;
        state <= S_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign md.md_busy  = (state == S_RUN);
  assign md.md_stall = md.D_md_req & ((state == S_RUN) | (md.E_md_start & long_op));
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.md_err   = err_q;
  assign dbg_state   = state;
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: MULT/DIV results and latency, MTHI/MTLO,
// stall/error behaviour, asynchronous reset and the optional MADD path.
module tb_e_mdu_ctrl;
  logic       clk;
  logic       reset;
  logic [0:0] dbg_state;
  int tests_run;
  int tests_failed;

  e_mdu_ctrl_if md ();

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md        (md.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.E_md_start = 1'b1;
    md.E_md_op    = op;
    md.E_RS_DATA  = a;
    md.E_RT_DATA  = b;
    @(negedge clk);
    md.E_md_start = 1'b0;
    md.E_md_op    = 4'd0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (md.md_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: busy timeout after %0d cycles", name, n);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    md.E_md_start = 1'b0; md.E_md_op = 4'd0;
    md.E_RS_DATA = 32'd0; md.E_RT_DATA = 32'd0; md.D_md_req = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hi", md.HI, 32'd0);
    chk("reset_lo", md.LO, 32'd0);
    chk("reset_busy", {31'd0, md.md_busy}, 32'd0);
    chk("reset_err", {31'd0, md.md_err}, 32'd0);
    chk("reset_stall", {31'd0, md.md_stall}, 32'd0);
    chk("reset_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    md.D_md_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult", n);
    chk("mult_cycles", n, 5);
    chk("mult_hi", md.HI, 32'hFFFF_FFFF);
    chk("mult_lo", md.LO, 32'hFFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu", n);
    chk("multu_cycles", n, 5);
    chk("multu_hi", md.HI, 32'h0000_0002);
    chk("multu_lo", md.LO, 32'hFFFF_FFFA);
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_hold_hi", md.HI, 32'h0000_0002);
    wait_idle("div", n);
    chk("div_cycles", n, 10);
    chk("div_lo", md.LO, 32'hFFFF_FFFD);
    chk("div_hi", md.HI, 32'hFFFF_FFFF);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle("divu0", n);
    chk("divu0_cycles", n, 10);
    chk("divu0_hi", md.HI, 32'hFFFF_FFFF);
    chk("divu0_lo", md.LO, 32'hFFFF_FFFD);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf", n);
    chk("div_ovf_lo", md.LO, 32'h8000_0000);
    chk("div_ovf_hi", md.HI, 32'h0000_0000);
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_neg_dvs", n);
    chk("div_neg_dvs_lo", md.LO, 32'hFFFF_FFFD);
    chk("div_neg_dvs_hi", md.HI, 32'h0000_0001);
    issue(4'd4, 32'd100, 32'd7);
    wait_idle("divu", n);
    chk("divu_lo", md.LO, 32'd14);
    chk("divu_hi", md.HI, 32'd2);
  endtask

  task automatic test_mt();
    @(negedge clk);
    md.E_md_start = 1'b1; md.E_md_op = 4'd5; md.E_RS_DATA = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", md.HI, 32'h1234_5678);
    chk("mthi_busy", {31'd0, md.md_busy}, 32'd0);
    md.E_md_op = 4'd6; md.E_RS_DATA = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo_lo", md.LO, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", md.HI, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, md.md_busy}, 32'd0);
    md.E_md_start = 1'b0; md.E_md_op = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_stall_err();
    int n;
    int bad_stall;
    md.D_md_req = 1'b1;
    @(negedge clk);
    md.E_md_start = 1'b1; md.E_md_op = 4'd3; md.E_RS_DATA = 32'd100; md.E_RT_DATA = 32'd7;
    #1 chk("stall_on_issue", {31'd0, md.md_stall}, 32'd1);
    @(negedge clk);
    md.E_md_start = 1'b0; md.E_md_op = 4'd0;
    n = 0; bad_stall = 0;
    while (md.md_busy && n < 40) begin
      n++;
      if (md.md_stall !== 1'b1) bad_stall++;
      if (n == 3) begin
        md.E_md_start = 1'b1; md.E_md_op = 4'd1;
        md.E_RS_DATA = 32'd3; md.E_RT_DATA = 32'd4;
      end else begin
        md.E_md_start = 1'b0; md.E_md_op = 4'd0;
      end
      @(negedge clk);
    end
    md.E_md_start = 1'b0; md.E_md_op = 4'd0;
    chk("busy_run_cycles", n, 10);
    chk("stall_while_busy", bad_stall, 0);
    chk("stall_first_idle", {31'd0, md.md_stall}, 32'd0);
    chk("err_sticky", {31'd0, md.md_err}, 32'd1);
    chk("div_kept_lo", md.LO, 32'd14);
    chk("div_kept_hi", md.HI, 32'd2);
    repeat (6) @(negedge clk);
    chk("no_late_mult", {31'd0, md.md_busy}, 32'd0);
    chk("err_still_set", {31'd0, md.md_err}, 32'd1);
    md.D_md_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(4'd1, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", {31'd0, md.md_busy}, 32'd0);
    chk("async_hi", md.HI, 32'd0);
    chk("async_lo", md.LO, 32'd0);
    chk("async_err", {31'd0, md.md_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    md.D_md_req = 1'b1;
    #1 chk("post_reset_stall", {31'd0, md.md_stall}, 32'd0);
    repeat (6) @(negedge clk);
    chk("discard_busy", {31'd0, md.md_busy}, 32'd0);
    chk("discard_lo", md.LO, 32'd0);
    md.D_md_req = 1'b0;
  endtask

  task automatic test_madd();
    int n;
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    md.D_md_req = 1'b1;
    @(negedge clk);
    md.E_md_start = 1'b1; md.E_md_op = 4'd8; md.E_RS_DATA = 32'd1; md.E_RT_DATA = 32'd1;
`ifdef MDU_MADD_EN
    #1 chk("maddu_stall", {31'd0, md.md_stall}, 32'd1);
`else
    #1 chk("maddu_stall", {31'd0, md.md_stall}, 32'd0);
`endif
    @(negedge clk);
    md.E_md_start = 1'b0; md.E_md_op = 4'd0; md.D_md_req = 1'b0;
    wait_idle("maddu", n);
`ifdef MDU_MADD_EN
    chk("maddu_cycles", n, 5);
    chk("maddu_hi", md.HI, 32'd1);
    chk("maddu_lo", md.LO, 32'd0);
`else
    chk("maddu_cycles", n, 0);
    chk("maddu_hi", md.HI, 32'd0);
    chk("maddu_lo", md.LO, 32'hFFFF_FFFF);
`endif
    chk("maddu_err", {31'd0, md.md_err}, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_stall_err();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
